usb_trans_ctrl: RTL

Protocol-layer transaction sequencer for the full-speed USB device core. It sits between the packet receiver/decoder and the packet transmitter, and decides the device response to each token addressed to it. It enforces bus turnaround and timeout timing at 48 MHz (4 clocks per bit), tracks the per-endpoint DATA0/DATA1 toggle, and tells the endpoint buffers when to commit or discard received data.

---
 rtl/usb_trans_ctrl.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/usb_trans_ctrl.sv
// Full-speed USB device transaction sequencer: token decode, turnaround and
// timeout timing, per-endpoint data toggle and handshake generation.
module usb_trans_ctrl #(
  parameter int NUM_EP       = 4,
  parameter int TA_CLKS      = 8,
  parameter int TIMEOUT_CLKS = 72
) (
  input  logic       clk_48m,
  input  logic       rst,
  input  logic [6:0] dev_addr,
  input  logic       rx_active,
  input  logic       rx_pkt_valid,
  input  logic       rx_pkt_err,
  input  logic [3:0] rx_pid,
  input  logic [6:0] rx_addr,
  input  logic [3:0] rx_endp,
  output logic [3:0] ep_sel,
  input  logic       ep_in_ready,
  input  logic       ep_out_ready,
  input  logic       ep_stall,
  output logic       out_commit,
  output logic       out_discard,
  output logic       in_ack,
  output logic       tx_start,
  output logic [3:0] tx_pid,
  output logic       tx_data_en,
  input  logic       tx_busy,
  input  logic       tx_done,
  output logic       trans_active
);

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_SETUP = 4'b1101;
  localparam logic [3:0] PID_DATA0 = 4'b0011;
  localparam logic [3:0] PID_DATA1 = 4'b1011;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  localparam int EP_W    = (NUM_EP > 1) ? $clog2(NUM_EP) : 1;
  localparam int CNT_MAX = (TIMEOUT_CLKS > TA_CLKS) ? TIMEOUT_CLKS : TA_CLKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // The decision is registered one cycle before tx_start, so turnaround ends at TA_CLKS-2.
  localparam logic [CNT_W-1:0] TA_LAST = CNT_W'(TA_CLKS - 2);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {IDLE, IN_TA, WAIT_DATA, DATA_TA, TX, WAIT_HS} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [NUM_EP-1:0] toggle;
  logic [EP_W-1:0]   ep_idx;
  logic              is_setup;
  logic              data1;
  logic              tx_sent;

  function automatic logic is_token(input logic [3:0] pid);
    return (pid == PID_OUT) || (pid == PID_IN) || (pid == PID_SETUP);
  endfunction

  function automatic logic is_data(input logic [3:0] pid);
    return pid[2:0] == 3'b011;
  endfunction

  logic pkt_ok, token_hit, addr_hit, timed_out;
  assign pkt_ok    = rx_pkt_valid && !rx_pkt_err;
  assign token_hit = pkt_ok && is_token(rx_pid);
  assign addr_hit  = (rx_addr == dev_addr) && (32'(rx_endp) < 32'(NUM_EP));
  assign timed_out = !rx_active && (cnt == TO_LAST);

  always_ff @(posedge clk_48m) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      toggle       <= '0;
      ep_idx       <= '0;
      is_setup     <= 1'b0;
      data1        <= 1'b0;
      tx_sent      <= 1'b0;
      ep_sel       <= '0;
      out_commit   <= 1'b0;
      out_discard  <= 1'b0;
      in_ack       <= 1'b0;
      tx_start     <= 1'b0;
      tx_pid       <= '0;
      tx_data_en   <= 1'b0;
      trans_active <= 1'b0;
    end else begin
      out_commit  <= 1'b0;
      out_discard <= 1'b0;
      in_ack      <= 1'b0;
      tx_start    <= 1'b0;
      if (state != IDLE && token_hit) begin
        // A fresh token ends the current transaction; received OUT data is dropped.
        state        <= IDLE;
        trans_active <= 1'b0;
        tx_pid       <= '0;
        tx_data_en   <= 1'b0;
        out_discard  <= (state == WAIT_DATA) || (state == DATA_TA);
      end else begin
        case (state)
          IDLE: begin
            if (token_hit && addr_hit) begin
              ep_sel       <= rx_endp;
              ep_idx       <= rx_endp[EP_W-1:0];
              is_setup     <= (rx_pid == PID_SETUP);
              cnt          <= '0;
              trans_active <= 1'b1;
              state        <= (rx_pid == PID_IN) ? IN_TA : WAIT_DATA;
            end
          end
          IN_TA: begin
            if (cnt == TA_LAST) begin
              state   <= TX;
              tx_sent <= 1'b0;
              if (ep_stall) begin
                tx_pid <= PID_STALL;
              end else if (!ep_in_ready) begin
                tx_pid <= PID_NAK;
              end else begin
                tx_pid     <= toggle[ep_idx] ? PID_DATA1 : PID_DATA0;
                tx_data_en <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_DATA: begin
            if (rx_pkt_err || (rx_pkt_valid && !is_data(rx_pid)) ||
                (!rx_pkt_valid && timed_out)) begin
              state        <= IDLE;
              trans_active <= 1'b0;
              out_discard  <= 1'b1;
            end else if (rx_pkt_valid) begin
              state <= DATA_TA;
              data1 <= rx_pid[3];
              cnt   <= '0;
            end else if (!rx_active) begin
              cnt <= cnt + 1'b1;
            end
          end
          DATA_TA: begin
            if (cnt == TA_LAST) begin
              state   <= TX;
              tx_sent <= 1'b0;
              tx_pid  <= PID_ACK;
              if (is_setup) begin
                if (!data1) begin
                  out_commit     <= 1'b1;
                  toggle[ep_idx] <= 1'b1;
                end else begin
                  tx_pid       <= '0;
                  out_discard  <= 1'b1;
                  state        <= IDLE;
                  trans_active <= 1'b0;
                end
              end else if (ep_stall) begin
                tx_pid      <= PID_STALL;
                out_discard <= 1'b1;
              end else if (!ep_out_ready) begin
                tx_pid      <= PID_NAK;
                out_discard <= 1'b1;
              end else if (data1 != toggle[ep_idx]) begin
                out_discard <= 1'b1;
              end else begin
                out_commit     <= 1'b1;
                toggle[ep_idx] <= ~toggle[ep_idx];
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          TX: begin
            if (!tx_sent && !tx_busy) begin
              tx_start <= 1'b1;
              tx_sent  <= 1'b1;
            end
            if (tx_sent && tx_done) begin
              tx_pid     <= '0;
              tx_data_en <= 1'b0;
              cnt        <= '0;
              if (tx_data_en) begin
                state <= WAIT_HS;
              end else begin
                state        <= IDLE;
                trans_active <= 1'b0;
              end
            end
          end
          WAIT_HS: begin
            if (rx_pkt_err || rx_pkt_valid || timed_out) begin
              state        <= IDLE;
              trans_active <= 1'b0;
              if (pkt_ok && rx_pid == PID_ACK) begin
                in_ack         <= 1'b1;
                toggle[ep_idx] <= ~toggle[ep_idx];
              end
            end else if (!rx_active) begin
              cnt <= cnt + 1'b1;
            end
          end
          default: begin
            state        <= IDLE;
            trans_active <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
